wb_stage: RTL and testbench

Writeback stage of the five-stage RV32I core: the producer side of the register file write port. It accepts one retiring instruction per cycle from the MEM stage, selects and formats the result (ALU, sign/zero-extended load, PC+4), and drives the register file write port (`wr_en`, `addr_wr`, `data_wr`) from registers one cycle later. It also counts retired instructions and flags misaligned loads.

---
 rtl/my_pkg.sv | 10 +
 rtl/wb_stage_if.sv | 24 ++
 rtl/load_align.sv | 26 ++
 rtl/wb_stage.sv | 54 +++++
 tb/tb_wb_stage.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/my_pkg.sv
// my_pkg: shared datapath width, writeback source select and load funct3 codes.
package my_pkg;
  localparam int DATA_WIDTH = 32;
  typedef enum logic [1:0] {WB_ALU = 2'b00, WB_LOAD = 2'b01, WB_PC4 = 2'b10} wb_sel_t;
  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;
endpackage

// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM-to-WB retiring instruction bus with acceptance handshake and global stall.
interface wb_stage_if #(parameter int DATA_WIDTH = my_pkg::DATA_WIDTH);
  logic                  mem_valid;
  logic                  mem_ready;
  logic                  wb_hold;
  logic                  mem_rd_we;
  logic [4:0]            mem_rd;
  logic [1:0]            mem_wb_sel;
  logic [2:0]            mem_load_type;
  logic [1:0]            mem_addr_lo;
  logic [DATA_WIDTH-1:0] mem_alu_result;
  logic [DATA_WIDTH-1:0] mem_pc_plus4;
  logic [DATA_WIDTH-1:0] mem_load_data;
  modport master (
    output mem_valid, wb_hold, mem_rd_we, mem_rd, mem_wb_sel, mem_load_type, mem_addr_lo,
           mem_alu_result, mem_pc_plus4, mem_load_data,
    input  mem_ready
  );
  modport slave (
    input  mem_valid, wb_hold, mem_rd_we, mem_rd, mem_wb_sel, mem_load_type, mem_addr_lo,
           mem_alu_result, mem_pc_plus4, mem_load_data,
    output mem_ready
  );
endinterface

// File: rtl/load_align.sv
// load_align: extracts and extends the addressed byte/half of a loaded word and flags misalignment.
module load_align import my_pkg::*; #(
  parameter int DATA_WIDTH = my_pkg::DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] raw,
  input  logic [2:0]            load_type,
  input  logic [1:0]            addr_lo,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  misaligned
);
  logic [7:0]  b;
  logic [15:0] h;
  logic        is_b, is_h;
  always_comb begin
    b = raw[{addr_lo, 3'b000} +: 8];
    h = raw[{addr_lo[1], 4'b0000} +: 16];
    is_b = load_type == LD_B || load_type == LD_BU;
    is_h = load_type == LD_H || load_type == LD_HU;
    data = load_type == LD_B  ? {{(DATA_WIDTH-8){b[7]}}, b} :
           load_type == LD_BU ? {{(DATA_WIDTH-8){1'b0}}, b} :
           load_type == LD_H  ? {{(DATA_WIDTH-16){h[15]}}, h} :
           load_type == LD_HU ? {{(DATA_WIDTH-16){1'b0}}, h} : raw;
    // unknown funct3 codes behave as LW, so they need word alignment too
    misaligned = is_h ? addr_lo[0] : !is_b && addr_lo != 2'd0;
  end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: selects/formats the retiring result and drives the registered register-file write port.
module wb_stage import my_pkg::*; #(
  parameter int DATA_WIDTH = my_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  wb_stage_if.slave             m,
  output logic                  wr_en,
  output logic [4:0]            addr_wr,
  output logic [DATA_WIDTH-1:0] data_wr,
  output logic [63:0]           instret,
  output logic                  load_misalign
);
  logic [DATA_WIDTH-1:0] ld_data, result;
  logic                  ld_mis, accept, mis, we, wb_valid;
  logic [63:0]           cnt_q;
  wb_sel_t               sel;
  load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .raw(m.mem_load_data),
    .load_type(m.mem_load_type),
    .addr_lo(m.mem_addr_lo),
    .data(ld_data),
    .misaligned(ld_mis)
  );
  assign m.mem_ready = rst_n && !m.wb_hold;
  assign instret = cnt_q;
  always_comb begin
    sel = wb_sel_t'(m.mem_wb_sel);
    accept = m.mem_valid && m.mem_ready;
    mis = sel == WB_LOAD && ld_mis;
    we = accept && m.mem_rd_we && m.mem_rd != 5'd0 && !mis;
    result = sel == WB_LOAD ? ld_data : sel == WB_PC4 ? m.mem_pc_plus4 : m.mem_alu_result;
  end
  // the counter lags acceptance by one edge so it moves together with the register file commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wr_en <= 1'b0;
      load_misalign <= 1'b0;
      addr_wr <= '0;
      data_wr <= '0;
      cnt_q <= '0;
    end else begin
      wb_valid <= accept;
      wr_en <= we;
      load_misalign <= accept && mis;
      if (we) begin
        addr_wr <= m.mem_rd;
        data_wr <= result;
      end
      if (wb_valid && !load_misalign) cnt_q <= cnt_q + 64'd1;
    end
  end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed and random stimulus with a queue scoreboard against a behavioural writeback model.
module tb_wb_stage;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        wr_en, load_misalign;
  logic [4:0]  addr_wr;
  logic [31:0] data_wr;
  logic [63:0] instret;
  int vectors = 0, miscompares = 0;
  typedef struct packed {logic wr; logic [4:0] a; logic [31:0] d; logic mis; logic [63:0] ir;} exp_t;
  typedef struct {bit v, hold, we; bit [4:0] rd; bit [1:0] sel; bit [2:0] lt; bit [1:0] o; bit [31:0] alu, pc4, raw;} stim_t;
  exp_t        q[$];
  logic [63:0] cnt_m = 0;
  logic [4:0]  last_a = 0;
  logic [31:0] last_d = 0;
  wb_stage_if bus();
  wb_stage dut (.clk(clk), .rst_n(rst_n), .m(bus.slave), .wr_en(wr_en), .addr_wr(addr_wr),
                .data_wr(data_wr), .instret(instret), .load_misalign(load_misalign));
  always #5 clk = ~clk;
  function automatic stim_t mk(bit v, bit hold, bit we, bit [4:0] rd, bit [1:0] sel, bit [2:0] lt,
                               bit [1:0] o, bit [31:0] alu, bit [31:0] pc4, bit [31:0] raw);
    stim_t s;
    s.v = v; s.hold = hold; s.we = we; s.rd = rd; s.sel = sel; s.lt = lt; s.o = o;
    s.alu = alu; s.pc4 = pc4; s.raw = raw;
    return s;
  endfunction
  function automatic bit [31:0] ref_load(bit [2:0] lt, bit [1:0] o, bit [31:0] raw, output bit mis);
    bit [31:0] sb, sh;
    sb = raw >> (8 * o);
    sh = raw >> (16 * o[1]);
    mis = 0;
    case (lt)
      3'd0: return 32'($signed(sb[7:0]));
      3'd4: return sb & 32'hFF;
      3'd1: begin mis = o[0]; return 32'($signed(sh[15:0])); end
      3'd5: begin mis = o[0]; return sh & 32'hFFFF; end
      default: begin mis = o != 0; return raw; end
    endcase
  endfunction
  task automatic chk(string name, logic [63:0] got, logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask
  task automatic drive(stim_t s, bit preload = 0);
    bit [31:0] ld, res;
    bit lmis, mis, acc, wr;
    @(negedge clk);
    bus.mem_valid = s.v; bus.wb_hold = s.hold; bus.mem_rd_we = s.we; bus.mem_rd = s.rd;
    bus.mem_wb_sel = s.sel; bus.mem_load_type = s.lt; bus.mem_addr_lo = s.o;
    bus.mem_alu_result = s.alu; bus.mem_pc_plus4 = s.pc4; bus.mem_load_data = s.raw;
    if (preload) begin
      dut.cnt_q = '1;
      cnt_m = '1;
    end
    ld = ref_load(s.lt, s.o, s.raw, lmis);
    mis = s.sel == 2'd1 && lmis;
    res = s.sel == 2'd1 ? ld : s.sel == 2'd2 ? s.pc4 : s.alu;
    acc = s.v && !s.hold;
    wr = acc && s.we && s.rd != 0 && !mis;
    if (wr) begin
      last_a = s.rd;
      last_d = res;
    end
    q.push_back('{wr, last_a, last_d, acc && mis, cnt_m});
    if (acc && !mis) cnt_m = cnt_m + 64'd1;
  endtask
  task automatic idle();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        vectors++;
        if ({wr_en, addr_wr, data_wr, load_misalign, instret} !== e) begin
          miscompares++;
          $display("FAIL scoreboard t=%0t: got wr=%b a=%0d d=%h mis=%b ir=%h expected wr=%b a=%0d d=%h mis=%b ir=%h",
                   $time, wr_en, addr_wr, data_wr, load_misalign, instret, e.wr, e.a, e.d, e.mis, e.ir);
        end
      end
    end
  end
  initial begin : stim
    bus.mem_valid = 0; bus.wb_hold = 0; bus.mem_rd_we = 0; bus.mem_rd = 0; bus.mem_wb_sel = 0;
    bus.mem_load_type = 0; bus.mem_addr_lo = 0; bus.mem_alu_result = 0; bus.mem_pc_plus4 = 0;
    bus.mem_load_data = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_addr", addr_wr, 0);
    chk("rst_data", data_wr, 0);
    chk("rst_instret", instret, 0);
    chk("rst_misalign", load_misalign, 0);
    chk("rst_ready", bus.mem_ready, 0);
    @(negedge clk);
    rst_n = 1;
    #1 chk("ready_after_rst", bus.mem_ready, 1);
    drive(mk(1, 0, 1, 5, 0, 3'd2, 0, 32'h1234_5678, 0, 0));
    @(posedge clk); #2;
    chk("alu_wr_en", wr_en, 1);
    chk("alu_addr", addr_wr, 5);
    chk("alu_data", data_wr, 32'h1234_5678);
    idle();
    @(posedge clk); #2;
    chk("alu_instret", instret, 1);
    drive(mk(1, 0, 1, 7, 1, 3'd0, 1, 0, 0, 32'h80FF_7F01));
    @(posedge clk); #2 chk("lb_o1", data_wr, 32'h0000_007F);
    drive(mk(1, 0, 1, 7, 1, 3'd4, 1, 0, 0, 32'h80FF_7F01));
    @(posedge clk); #2 chk("lbu_o1", data_wr, 32'h0000_007F);
    drive(mk(1, 0, 1, 7, 1, 3'd1, 2, 0, 0, 32'h80FF_7F01));
    @(posedge clk); #2 chk("lh_o2", data_wr, 32'hFFFF_80FF);
    drive(mk(1, 0, 1, 7, 1, 3'd5, 2, 0, 0, 32'h80FF_7F01));
    @(posedge clk); #2 chk("lhu_o2", data_wr, 32'h0000_80FF);
    drive(mk(1, 0, 1, 8, 2, 0, 0, 32'hDEAD_0000, 32'h0000_1004, 0));
    drive(mk(1, 0, 1, 0, 0, 0, 0, 32'hAAAA_AAAA, 0, 0));
    drive(mk(1, 0, 0, 3, 0, 0, 0, 32'hBBBB_BBBB, 0, 0));
    drive(mk(1, 0, 1, 9, 1, 3'd2, 2, 0, 0, 32'hCAFE_F00D));
    @(posedge clk); #2;
    chk("mis_pulse", load_misalign, 1);
    chk("mis_no_write", wr_en, 0);
    drive(mk(1, 0, 1, 10, 0, 0, 0, 32'h0BAD_BEEF, 0, 0));
    @(posedge clk); #2 chk("after_mis_write", wr_en, 1);
    for (int i = 0; i < 3; i++) drive(mk(1, 0, 1, 5'(11 + i), 0, 0, 0, 32'(i + 100), 0, 0));
    for (int i = 0; i < 2; i++) drive(mk(1, 1, 1, 20, 0, 0, 0, 32'hFFFF_0000, 0, 0));
    drive(mk(1, 0, 1, 11, 0, 0, 0, 32'h0000_0200, 0, 0));
    idle();
    for (int i = 0; i < 400; i++)
      drive(mk($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0,
               5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
               2'($urandom_range(0, 3)), $urandom, $urandom, $urandom));
    idle();
    drive(mk(1, 0, 1, 4, 0, 0, 0, 32'h0000_0042, 0, 0), 1);
    idle();
    @(posedge clk); #2 chk("instret_wrap", instret, 0);
    drive(mk(1, 0, 1, 12, 0, 0, 0, 32'h5555_AAAA, 0, 0));
    @(negedge clk);
    rst_n = 0;
    bus.mem_valid = 0;
    q.delete();
    cnt_m = 0; last_a = 0; last_d = 0;
    #1;
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_data", data_wr, 0);
    chk("midrst_instret", instret, 0);
    @(posedge clk); #2 chk("midrst_no_write", wr_en, 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 20; i++)
      drive(mk($urandom_range(0, 1), 0, 1, 5'($urandom_range(1, 31)), 2'($urandom_range(0, 2)),
               3'($urandom_range(0, 5)), 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom));
    repeat (3) idle();
    @(posedge clk); #3;
    chk("queue_drained", 64'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
